// File: rtl/arb_pkg.sv
// Shared types and default sizes for the register-bank write arbiter.
package arb_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

  // 2'b11 is unreachable and falls into the IDLE branch of the FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    COMMIT = 2'b10
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, with wrap.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);
  always_comb begin
    int j;
    logic [PTR_W-1:0] jj;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    j      = 0;
    jj     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j -= N_REQ;
      jj = PTR_W'(j);
      if (!valid && req[jj]) begin
        valid      = 1'b1;
        idx        = jj;
        onehot[jj] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin write arbiter in front of a DFF register bank, with an async read port.
module regbank_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ  = N_REQ_DEF,
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] wr_addr,
  input  logic [N_REQ*WIDTH-1:0]  wr_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    busy
);
  localparam int PTR_W = $clog2(N_REQ);

  state_t            state;
  logic [PTR_W-1:0]  ptr, win;
  logic [N_REQ-1:0]  pick_oh, win_oh;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data;
  logic [WIDTH-1:0]  bank [DEPTH];

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  assign w_addr  = wr_addr[win*ADDR_W +: ADDR_W];
  assign w_data  = wr_data[win*WIDTH +: WIDTH];
  assign win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << win;
  assign rd_data = bank[rd_addr];
  assign busy    = (state == GRANT) || (state == COMMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      ack   <= '0;
      ptr   <= '0;
      win   <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      case (state)
        GRANT: begin
          gnt <= '0;
          // Winner dropping req before commit aborts without touching ptr.
          if (req[win]) begin
            bank[w_addr] <= w_data;
            ack          <= win_oh;
            ptr          <= (win == PTR_W'(N_REQ-1)) ? '0 : win + 1'b1;
            state        <= COMMIT;
          end else begin
            state <= IDLE;
          end
        end
        COMMIT: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: begin
          ack <= '0;
          if (pick_vld) begin
            gnt   <= pick_oh;
            win   <= pick_idx;
            state <= GRANT;
          end else begin
            gnt   <= '0;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench: table of transactions, corner sequences, then random traffic vs a model.
module tb_regbank_arbiter;
  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  gnt, ack;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mbank [8];
  int         mptr;

  typedef struct {
    logic [3:0]  r;
    logic [11:0] a;
    logic [31:0] d;
    int          w;
  } vec_t;

  vec_t tbl [11];

  regbank_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .ack     (ack),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Winner = requesting index with the smallest forward distance from ptr.
  function automatic int model_win(input logic [3:0] r);
    int best, bd;
    best = -1;
    bd   = 99;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        int dd;
        dd = (i - mptr + 4) % 4;
        if (dd < bd) begin
          bd   = dd;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 8; i++) mbank[i] = 8'h00;
    mptr = 0;
  endtask

  // One full transaction starting in IDLE; exp_w < 0 means take the winner from the model.
  task automatic txn(input string nm, input logic [3:0] r, input logic [11:0] a,
                     input logic [31:0] d, input bit abort_it, input int exp_w);
    int w;
    logic [2:0] ea;
    logic [7:0] ed;
    logic [3:0] oh;
    w  = (exp_w < 0) ? model_win(r) : exp_w;
    oh = 4'b0001 << w;
    ea = a[w*3 +: 3];
    ed = d[w*8 +: 8];
    req = r; wr_addr = a; wr_data = d;
    tick;
    chk({nm, ".gnt"}, gnt, oh);
    chk({nm, ".ack0"}, ack, 4'b0000);
    chk({nm, ".busy_g"}, busy, 1'b1);
    rd_addr = ea;
    #1;
    chk({nm, ".rd_old"}, rd_data, mbank[ea]);
    if (abort_it) begin
      req = 4'b0000;
      tick;
      chk({nm, ".ab_ack"}, ack, 4'b0000);
      chk({nm, ".ab_gnt"}, gnt, 4'b0000);
      chk({nm, ".ab_busy"}, busy, 1'b0);
      chk({nm, ".ab_rd"}, rd_data, mbank[ea]);
    end else begin
      tick;
      chk({nm, ".ack"}, ack, oh);
      chk({nm, ".gnt0"}, gnt, 4'b0000);
      chk({nm, ".busy_c"}, busy, 1'b1);
      chk({nm, ".rd_new"}, rd_data, ed);
      mbank[ea] = ed;
      mptr      = (w + 1) % 4;
      req = 4'b0000;
      tick;
      chk({nm, ".idle_busy"}, busy, 1'b0);
      chk({nm, ".idle_ack"}, ack, 4'b0000);
      chk({nm, ".rd_keep"}, rd_data, ed);
    end
  endtask

  initial begin
    reset = 1'b0; req = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    model_reset();
    #1;
    chk("rst.gnt", gnt, 4'b0000);
    chk("rst.ack", ack, 4'b0000);
    chk("rst.busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("rst.rd", rd_data, 8'h00);
    end
    @(negedge clk);
    reset = 1'b1;
    tick;
    chk("idle.gnt", gnt, 4'b0000);
    chk("idle.busy", busy, 1'b0);

    for (int n = 0; n < 11; n++) begin
      for (int i = 0; i < 4; i++) begin
        tbl[n].a[i*3 +: 3] = 3'((n*3 + i) % 8);
        tbl[n].d[i*8 +: 8] = 8'(n*16 + i + 1);
      end
    end
    tbl[0].r  = 4'b1111; tbl[0].w  = 0;
    tbl[1].r  = 4'b1111; tbl[1].w  = 1;
    tbl[2].r  = 4'b1111; tbl[2].w  = 2;
    tbl[3].r  = 4'b1111; tbl[3].w  = 3;
    tbl[4].r  = 4'b1111; tbl[4].w  = 0;
    tbl[5].r  = 4'b0010; tbl[5].w  = 1;
    tbl[5].a[5:3]  = 3'd3; tbl[5].d[15:8] = 8'hA5;
    tbl[6].r  = 4'b1001; tbl[6].w  = 3;
    tbl[7].r  = 4'b0001; tbl[7].w  = 0;
    tbl[7].a[2:0]  = 3'd6; tbl[7].d[7:0]  = 8'h11;
    tbl[8].r  = 4'b0001; tbl[8].w  = 0;
    tbl[8].a[2:0]  = 3'd6; tbl[8].d[7:0]  = 8'h22;
    tbl[9].r  = 4'b0110; tbl[9].w  = 1;
    tbl[10].r = 4'b0010; tbl[10].w = 1;
    for (int n = 0; n < 11; n++)
      txn($sformatf("tbl%0d", n), tbl[n].r, tbl[n].a, tbl[n].d, 1'b0, tbl[n].w);

    // ptr is 2 here: requester 2 aborts, then must win again over requester 3.
    txn("abort", 4'b0100, 12'o7654, 32'h44332211, 1'b1, 2);
    txn("reabort", 4'b1110, 12'o7654, 32'h44332211, 1'b0, 2);

    // Reset in GRANT: write to addr 5 must never land, ptr returns to 0.
    req = 4'b0001; wr_addr = 12'o0005; wr_data = 32'h0000003C;
    tick;
    chk("rstmid.gnt", gnt, 4'b0001);
    #2 reset = 1'b0;
    #1;
    chk("rstmid.gnt0", gnt, 4'b0000);
    chk("rstmid.ack0", ack, 4'b0000);
    chk("rstmid.busy", busy, 1'b0);
    model_reset();
    req = 4'b0000;
    rd_addr = 3'd5;
    #1;
    chk("rstmid.bank5", rd_data, 8'h00);
    tick;
    @(negedge clk);
    reset = 1'b1;
    tick;
    chk("rstmid.noack", ack, 4'b0000);
    chk("rstmid.idle", busy, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("rstmid.rd", rd_data, 8'h00);
    end
    txn("ptr0", 4'b1001, 12'o1234, 32'h5566_7788, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      txn($sformatf("rnd%0d", n), 4'($urandom_range(1, 15)), 12'($urandom), $urandom,
          ($urandom_range(0, 4) == 0), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
